// File: rtl/trigger_sequencer.sv
// Threshold trigger controller: arm -> qualify (edge) -> confirm run -> hold-off, one-cycle trigger pulse.
// Trigger is registered one cycle after the confirming sample; no backpressure, abort always wins.
module trigger_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arm,
    input  logic                   abort,
    input  logic                   auto_rearm,
    input  logic [2:0]             op_sel,
    input  logic [DATA_WIDTH-1:0]  threshold,
    input  logic [7:0]             confirm_len,
    input  logic [COUNT_WIDTH-1:0] holdoff,
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic                   data_valid,
    output logic                   trigger,
    output logic                   armed,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] trigger_count
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_QUALIFY = 2'd1;
    localparam logic [1:0] ST_SEARCH  = 2'd2;
    localparam logic [1:0] ST_HOLDOFF = 2'd3;

    logic [1:0]             r_state;
    logic [2:0]             r_op;
    logic [DATA_WIDTH-1:0]  r_thr;
    logic [7:0]             r_clen;
    logic [COUNT_WIDTH-1:0] r_hold;
    logic                   r_auto;
    logic [7:0]             r_run;
    logic [COUNT_WIDTH-1:0] r_hcnt;
    logic                   r_trig;
    logic [COUNT_WIDTH-1:0] r_count;

    logic       w_cond;
    logic [7:0] w_clen_eff;
    logic [8:0] w_run_inc;
    logic       w_confirm;
    logic [1:0] w_exit_state;

    always_comb begin
        w_cond = 1'b0;
        case (r_op)
            3'd0:    w_cond = (data == r_thr);
            3'd1:    w_cond = (data != r_thr);
            3'd2:    w_cond = (data >  r_thr);
            3'd3:    w_cond = (data >= r_thr);
            3'd4:    w_cond = (data <  r_thr);
            3'd5:    w_cond = (data <= r_thr);
            default: w_cond = 1'b0;
        endcase
    end

    // A latched confirm length of zero behaves as one.
    assign w_clen_eff   = (r_clen == 8'd0) ? 8'd1 : r_clen;
    assign w_run_inc    = {1'b0, r_run} + 9'd1;
    assign w_confirm    = data_valid && w_cond && (w_run_inc >= {1'b0, w_clen_eff});
    assign w_exit_state = r_auto ? ST_QUALIFY : ST_IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_thr   <= '0;
            r_clen  <= '0;
            r_hold  <= '0;
            r_auto  <= 1'b0;
            r_run   <= '0;
            r_hcnt  <= '0;
            r_trig  <= 1'b0;
            r_count <= '0;
        end else begin
            r_trig <= 1'b0;
            if (abort) begin
                r_state <= ST_IDLE;
                r_run   <= '0;
                r_hcnt  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (arm) begin
                            r_op    <= op_sel;
                            r_thr   <= threshold;
                            r_clen  <= confirm_len;
                            r_hold  <= holdoff;
                            r_auto  <= auto_rearm;
                            r_count <= '0;
                            r_run   <= '0;
                            r_state <= ST_QUALIFY;
                        end
                    end
                    ST_QUALIFY: begin
                        if (data_valid && !w_cond) begin
                            r_run   <= '0;
                            r_state <= ST_SEARCH;
                        end
                    end
                    ST_SEARCH: begin
                        if (w_confirm) begin
                            r_trig <= 1'b1;
                            r_run  <= '0;
                            if (r_count != {COUNT_WIDTH{1'b1}})
                                r_count <= r_count + COUNT_WIDTH'(1);
                            if (r_hold == '0) begin
                                r_state <= w_exit_state;
                            end else begin
                                r_hcnt  <= r_hold;
                                r_state <= ST_HOLDOFF;
                            end
                        end else if (data_valid) begin
                            r_run <= w_cond ? w_run_inc[7:0] : 8'd0;
                        end
                    end
                    default: begin
                        // Counter was loaded with H on entry; the edge that sees 1 ends the H-th cycle.
                        if (r_hcnt <= COUNT_WIDTH'(1)) begin
                            r_hcnt  <= '0;
                            r_state <= w_exit_state;
                        end else begin
                            r_hcnt <= r_hcnt - COUNT_WIDTH'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign trigger       = r_trig;
    assign armed         = (r_state == ST_QUALIFY) || (r_state == ST_SEARCH);
    assign busy          = (r_state != ST_IDLE);
    assign trigger_count = r_count;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Randomized and directed bench for trigger_sequencer against a phase-level reference model.
module tb_trigger_sequencer;

    logic        clk = 1'b0;
    logic        rst, arm, abort, auto_rearm, data_valid;
    logic [2:0]  op_sel;
    logic [15:0] threshold, data;
    logic [7:0]  confirm_len;
    logic [31:0] holdoff;

    logic        trig_a, armed_a, busy_a;
    logic [31:0] cnt_a;
    logic        trig_b, armed_b, busy_b;
    logic [3:0]  cnt_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    trigger_sequencer #(.DATA_WIDTH(16), .COUNT_WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort), .auto_rearm(auto_rearm),
        .op_sel(op_sel), .threshold(threshold), .confirm_len(confirm_len),
        .holdoff(holdoff), .data(data), .data_valid(data_valid),
        .trigger(trig_a), .armed(armed_a), .busy(busy_a), .trigger_count(cnt_a)
    );

    trigger_sequencer #(.DATA_WIDTH(16), .COUNT_WIDTH(4)) u_dut_sat (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort), .auto_rearm(auto_rearm),
        .op_sel(op_sel), .threshold(threshold), .confirm_len(confirm_len),
        .holdoff(holdoff[3:0]), .data(data), .data_valid(data_valid),
        .trigger(trig_b), .armed(armed_b), .busy(busy_b), .trigger_count(cnt_b)
    );

    // Reference: "active" = not idle, "need_false" = waiting for a false sample, "in_hold" = hold-off.
    typedef struct {
        bit              active;
        bit              need_false;
        bit              in_hold;
        longint unsigned hold_left;
        int unsigned     streak;
        bit              trig;
        longint unsigned count;
        bit [2:0]        op;
        bit [15:0]       thr;
        int unsigned     clen;
        longint unsigned hold;
        bit              auto_r;
    } mdl_t;

    mdl_t m_a, m_b;

    function automatic bit ref_cond(bit [2:0] op, bit [15:0] a, bit [15:0] b);
        int unsigned x = a;
        int unsigned y = b;
        case (op)
            3'd0: return x == y;
            3'd1: return x != y;
            3'd2: return x > y;
            3'd3: return x >= y;
            3'd4: return x < y;
            3'd5: return x <= y;
            default: return 1'b0;
        endcase
    endfunction

    function automatic mdl_t ref_step(mdl_t m, longint unsigned hold_in, longint unsigned sat);
        mdl_t n = m;
        bit   c;
        n.trig = 1'b0;
        if (rst) begin
            n = '{default: 0};
            return n;
        end
        if (abort) begin
            n.active  = 1'b0;
            n.in_hold = 1'b0;
            return n;
        end
        if (!m.active) begin
            if (arm) begin
                n.op = op_sel; n.thr = threshold; n.hold = hold_in; n.auto_r = auto_rearm;
                n.clen = (confirm_len == 0) ? 1 : confirm_len;
                n.count = 0; n.active = 1'b1; n.need_false = 1'b1; n.streak = 0;
            end
        end else if (m.in_hold) begin
            if (m.hold_left <= 1) begin
                n.in_hold = 1'b0;
                if (m.auto_r) n.need_false = 1'b1; else n.active = 1'b0;
            end else begin
                n.hold_left = m.hold_left - 1;
            end
        end else if (data_valid) begin
            c = ref_cond(m.op, data, m.thr);
            if (m.need_false) begin
                if (!c) begin n.need_false = 1'b0; n.streak = 0; end
            end else if (c && (m.streak + 1 >= m.clen)) begin
                n.trig = 1'b1;
                n.streak = 0;
                if (m.count < sat) n.count = m.count + 1;
                if (m.hold == 0) begin
                    if (m.auto_r) n.need_false = 1'b1; else n.active = 1'b0;
                end else begin
                    n.in_hold = 1'b1; n.hold_left = m.hold;
                end
            end else begin
                n.streak = c ? m.streak + 1 : 0;
            end
        end
        return n;
    endfunction

    task automatic check_val(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // One clock: advance both models from the current inputs, then compare after the edge.
    task automatic tick();
        mdl_t na, nb;
        na = ref_step(m_a, holdoff, 64'hFFFF_FFFF);
        nb = ref_step(m_b, holdoff & 32'hF, 15);
        @(posedge clk);
        m_a = na; m_b = nb;
        #1;
        check_val("trig",   trig_a,  m_a.trig);
        check_val("armed",  armed_a, m_a.active && !m_a.in_hold);
        check_val("busy",   busy_a,  m_a.active);
        check_val("count",  cnt_a,   m_a.count);
        check_val("trig4",  trig_b,  m_b.trig);
        check_val("count4", cnt_b,   m_b.count);
    endtask

    task automatic do_arm(input bit [2:0] op, input bit [15:0] thr, input bit [7:0] cl,
                          input bit [31:0] ho, input bit ar);
        op_sel = op; threshold = thr; confirm_len = cl; holdoff = ho; auto_rearm = ar;
        arm = 1'b1; data_valid = 1'b0;
        tick();
        arm = 1'b0;
    endtask

    task automatic sample(input bit [15:0] d);
        data = d; data_valid = 1'b1;
        tick();
    endtask

    int last_t, t, gap_min, trig_cnt;

    initial begin
        m_a = '{default: 0};
        m_b = '{default: 0};
        rst = 1'b1; arm = 1'b0; abort = 1'b0; auto_rearm = 1'b0; data_valid = 1'b0;
        op_sel = 3'd0; threshold = '0; data = '0; confirm_len = '0; holdoff = '0;
        tick();
        tick();
        rst = 1'b0;
        check_val("rst_busy", busy_a, 0);
        check_val("rst_cnt", cnt_a, 0);

        // GT edge trigger
        do_arm(3'd2, 16'd100, 8'd1, 32'd0, 1'b0);
        sample(16'd50);
        check_val("gt_no_trig", trig_a, 0);
        sample(16'd150);
        check_val("gt_trig", trig_a, 1);
        check_val("gt_cnt", cnt_a, 1);
        data_valid = 1'b0;
        tick();
        check_val("gt_idle", busy_a, 0);
        check_val("gt_single", trig_a, 0);

        // Condition already true at arm
        do_arm(3'd3, 16'd10, 8'd1, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            sample(16'd20);
            check_val("pre_true", trig_a, 0);
        end
        sample(16'd5);
        check_val("pre_low", trig_a, 0);
        sample(16'd20);
        check_val("edge_trig", trig_a, 1);

        // Confirmation with gaps
        do_arm(3'd0, 16'd7, 8'd3, 32'd0, 1'b0);
        sample(16'd1);
        sample(16'd7);
        sample(16'd7);
        data_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_val("gap_no_trig", trig_a, 0);
        sample(16'd3);
        sample(16'd7);
        sample(16'd7);
        check_val("run_short", trig_a, 0);
        sample(16'd7);
        check_val("run_trig", trig_a, 1);

        // Hold-off with auto re-arm; arm pulses while busy must be ignored
        do_arm(3'd4, 16'h8000, 8'd1, 32'd5, 1'b1);
        last_t = -1; gap_min = 1000; trig_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            arm = ($urandom_range(0, 3) == 0);
            sample((i % 2 == 0) ? 16'h9000 : 16'h1000);
            if (trig_a) begin
                trig_cnt++;
                if (last_t >= 0 && (i - last_t) < gap_min) gap_min = i - last_t;
                last_t = i;
            end
        end
        arm = 1'b0;
        check_val("ho_spacing_ge7", gap_min >= 7, 1);
        check_val("ho_count", cnt_a, trig_cnt);

        // Abort races
        abort = 1'b1; tick(); abort = 1'b0;
        do_arm(3'd2, 16'd100, 8'd1, 32'd0, 1'b0);
        sample(16'd50);
        abort = 1'b1;
        sample(16'd150);
        abort = 1'b0;
        check_val("abort_no_trig", trig_a, 0);
        check_val("abort_cnt", cnt_a, 0);
        check_val("abort_idle", busy_a, 0);
        arm = 1'b1; abort = 1'b1; data_valid = 1'b0;
        tick();
        arm = 1'b0; abort = 1'b0;
        check_val("arm_abort_idle", busy_a, 0);

        // Reset during hold-off
        do_arm(3'd2, 16'd100, 8'd1, 32'd20, 1'b1);
        sample(16'd50);
        sample(16'd150);
        sample(16'd150);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("rst_ho_busy", busy_a, 0);
        check_val("rst_ho_armed", armed_a, 0);
        check_val("rst_ho_trig", trig_a, 0);
        check_val("rst_ho_cnt", cnt_a, 0);

        // Saturation on the 4-bit instance
        do_arm(3'd2, 16'd100, 8'd1, 32'd0, 1'b1);
        trig_cnt = 0;
        for (int i = 0; i < 44; i++) begin
            sample((i % 2 == 0) ? 16'd50 : 16'd150);
            if (trig_b) trig_cnt++;
        end
        check_val("sat_pulses", trig_cnt, 22);
        check_val("sat_cnt4", cnt_b, 15);
        check_val("sat_cnt32", cnt_a, 22);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            abort       = ($urandom_range(0, 79) == 0);
            arm         = ($urandom_range(0, 5) == 0);
            auto_rearm  = $urandom_range(0, 1);
            op_sel      = 3'($urandom_range(0, 7));
            threshold   = 16'($urandom_range(0, 7));
            confirm_len = 8'($urandom_range(0, 3));
            holdoff     = 32'($urandom_range(0, 6));
            data        = 16'($urandom_range(0, 7));
            data_valid  = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
